// File: rtl/id_ex_stage_if.sv
// Decode/execute boundary bus: decode operands and control in, forwarding sources in,
// latched EX-stage fields and the load-use stall out.
interface id_ex_stage_if #(
    parameter int CTRL_W = 16
);
    logic              flush;
    logic              hold;
    logic              id_valid;
    logic [31:0]       id_pc;
    logic [4:0]        id_rs;
    logic [4:0]        id_rt;
    logic              id_uses_rt;
    logic [4:0]        id_dst;
    logic [31:0]       id_rdata1;
    logic [31:0]       id_rdata2;
    logic [31:0]       id_imm;
    logic [CTRL_W-1:0] id_ctrl;
    logic              id_regwrite;
    logic              id_memread;
    logic [31:0]       ex_alu_result;
    logic              exmem_regwrite;
    logic [4:0]        exmem_dst;
    logic [31:0]       exmem_result;
    logic              ex_valid;
    logic [31:0]       ex_pc;
    logic [31:0]       ex_opa;
    logic [31:0]       ex_opb;
    logic [31:0]       ex_imm;
    logic [CTRL_W-1:0] ex_ctrl;
    logic [4:0]        ex_dst;
    logic              ex_regwrite;
    logic              ex_memread;
    logic              load_use_stall;

    modport slave (
        input  flush, hold, id_valid, id_pc, id_rs, id_rt, id_uses_rt, id_dst,
               id_rdata1, id_rdata2, id_imm, id_ctrl, id_regwrite, id_memread,
               ex_alu_result, exmem_regwrite, exmem_dst, exmem_result,
        output ex_valid, ex_pc, ex_opa, ex_opb, ex_imm, ex_ctrl, ex_dst,
               ex_regwrite, ex_memread, load_use_stall
    );

    modport master (
        output flush, hold, id_valid, id_pc, id_rs, id_rt, id_uses_rt, id_dst,
               id_rdata1, id_rdata2, id_imm, id_ctrl, id_regwrite, id_memread,
               ex_alu_result, exmem_regwrite, exmem_dst, exmem_result,
        input  ex_valid, ex_pc, ex_opa, ex_opb, ex_imm, ex_ctrl, ex_dst,
               ex_regwrite, ex_memread, load_use_stall
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: forwards EX/MEM results onto the register-file operands,
// detects load-use hazards and latches the decoded instruction into EX.
module id_ex_stage #(
    parameter int CTRL_W = 16
) (
    input logic          clk,
    input logic          rst,
    id_ex_stage_if.slave bus
);
    logic              valid_q, valid_d;
    logic [31:0]       pc_q, pc_d;
    logic [31:0]       opa_q, opa_d;
    logic [31:0]       opb_q, opb_d;
    logic [31:0]       imm_q, imm_d;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [4:0]        dst_q, dst_d;
    logic              regwrite_q, regwrite_d;
    logic              memread_q, memread_d;

    logic              ex_fwd_en;
    logic [31:0]       fwd_a;
    logic [31:0]       fwd_b;
    logic              stall;

    // A load in EX has no data yet, so only non-load EX writers may forward.
    function automatic logic [31:0] forward(
        input logic [4:0]  src,
        input logic [31:0] rf_data,
        input logic        ex_en,
        input logic [4:0]  ex_dst,
        input logic [31:0] ex_res,
        input logic        mem_we,
        input logic [4:0]  mem_dst,
        input logic [31:0] mem_res
    );
        if (src == 5'd0)
            return 32'd0;
        else if (ex_en && ex_dst == src)
            return ex_res;
        else if (mem_we && mem_dst == src)
            return mem_res;
        else
            return rf_data;
    endfunction

    assign ex_fwd_en = valid_q & regwrite_q & ~memread_q;

    always_comb begin
        fwd_a = forward(bus.id_rs, bus.id_rdata1, ex_fwd_en, dst_q, bus.ex_alu_result,
                        bus.exmem_regwrite, bus.exmem_dst, bus.exmem_result);
        fwd_b = forward(bus.id_rt, bus.id_rdata2, ex_fwd_en, dst_q, bus.ex_alu_result,
                        bus.exmem_regwrite, bus.exmem_dst, bus.exmem_result);
    end

    always_comb begin
        stall = ~rst & ~bus.flush & bus.id_valid & valid_q & memread_q & (dst_q != 5'd0) &
                ((dst_q == bus.id_rs) | (bus.id_uses_rt & (dst_q == bus.id_rt)));
    end

    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        imm_d      = imm_q;
        ctrl_d     = ctrl_q;
        dst_d      = dst_q;
        regwrite_d = regwrite_q;
        memread_d  = memread_q;
        if (bus.flush || (!bus.hold && stall)) begin
            // Bubble: the whole EX register is cleared, not just the valid bit.
            valid_d    = 1'b0;
            pc_d       = 32'd0;
            opa_d      = 32'd0;
            opb_d      = 32'd0;
            imm_d      = 32'd0;
            ctrl_d     = '0;
            dst_d      = 5'd0;
            regwrite_d = 1'b0;
            memread_d  = 1'b0;
        end else if (!bus.hold) begin
            valid_d    = bus.id_valid;
            pc_d       = bus.id_pc;
            opa_d      = fwd_a;
            opb_d      = fwd_b;
            imm_d      = bus.id_imm;
            ctrl_d     = bus.id_ctrl;
            dst_d      = bus.id_dst;
            regwrite_d = bus.id_valid & bus.id_regwrite & (bus.id_dst != 5'd0);
            memread_d  = bus.id_valid & bus.id_memread;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            pc_q       <= 32'd0;
            opa_q      <= 32'd0;
            opb_q      <= 32'd0;
            imm_q      <= 32'd0;
            ctrl_q     <= '0;
            dst_q      <= 5'd0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            imm_q      <= imm_d;
            ctrl_q     <= ctrl_d;
            dst_q      <= dst_d;
            regwrite_q <= regwrite_d;
            memread_q  <= memread_d;
        end
    end

    assign bus.ex_valid       = valid_q;
    assign bus.ex_pc          = pc_q;
    assign bus.ex_opa         = opa_q;
    assign bus.ex_opb         = opb_q;
    assign bus.ex_imm         = imm_q;
    assign bus.ex_ctrl        = ctrl_q;
    assign bus.ex_dst         = dst_q;
    assign bus.ex_regwrite    = regwrite_q;
    assign bus.ex_memread     = memread_q;
    assign bus.load_use_stall = stall;
endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed hazard scenarios followed by random traffic.
module tb_id_ex_stage;
    localparam int CTRL_W = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    id_ex_stage_if #(.CTRL_W(CTRL_W)) bus ();
    id_ex_stage #(.CTRL_W(CTRL_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic        flush, hold, valid;
        logic [31:0] pc;
        logic [4:0]  rs, rt;
        logic        uses_rt;
        logic [4:0]  dst;
        logic [31:0] rd1, rd2, imm;
        logic [15:0] ctrl;
        logic        regwrite, memread;
        logic [31:0] alu;
        logic        mw;
        logic [4:0]  md;
        logic [31:0] mres;
    } stim_t;

    typedef struct {
        logic        valid;
        logic [31:0] pc, opa, opb, imm;
        logic [15:0] ctrl;
        logic [4:0]  dst;
        logic        rw, mr;
    } ex_t;

    int  checks = 0;
    int  errors = 0;
    ex_t m;
    ex_t sb_q[$];
    ex_t last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic ex_t zero_ex();
        ex_t e;
        e.valid = 0; e.pc = 0; e.opa = 0; e.opb = 0; e.imm = 0;
        e.ctrl = 0; e.dst = 0; e.rw = 0; e.mr = 0;
        return e;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s.flush = 0; s.hold = 0; s.valid = 0; s.pc = 0; s.rs = 0; s.rt = 0;
        s.uses_rt = 0; s.dst = 0; s.rd1 = 0; s.rd2 = 0; s.imm = 0; s.ctrl = 0;
        s.regwrite = 0; s.memread = 0; s.alu = 0; s.mw = 0; s.md = 0; s.mres = 0;
        return s;
    endfunction

    // Value the execute stage should see for one source register.
    function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] rf,
                                            input stim_t s, input ex_t e);
        if (r == 0) return 32'd0;
        if (e.valid && e.rw && !e.mr && e.dst == r) return s.alu;
        if (s.mw && s.md == r) return s.mres;
        return rf;
    endfunction

    function automatic logic must_stall(input stim_t s, input ex_t e);
        if (s.flush || !s.valid || !e.valid || !e.mr || e.dst == 0) return 1'b0;
        return (e.dst == s.rs) || (s.uses_rt && e.dst == s.rt);
    endfunction

    function automatic ex_t next_ex(input stim_t s, input ex_t e);
        ex_t n;
        if (s.flush) return zero_ex();
        if (s.hold) return e;
        if (must_stall(s, e)) return zero_ex();
        n.valid = s.valid;
        n.pc = s.pc;
        n.imm = s.imm;
        n.ctrl = s.ctrl;
        n.dst = s.dst;
        n.opa = operand(s.rs, s.rd1, s, e);
        n.opb = operand(s.rt, s.rd2, s, e);
        n.rw = s.valid && s.regwrite && s.dst != 0;
        n.mr = s.valid && s.memread;
        return n;
    endfunction

    task automatic apply(input stim_t s);
        bus.flush = s.flush; bus.hold = s.hold; bus.id_valid = s.valid;
        bus.id_pc = s.pc; bus.id_rs = s.rs; bus.id_rt = s.rt; bus.id_uses_rt = s.uses_rt;
        bus.id_dst = s.dst; bus.id_rdata1 = s.rd1; bus.id_rdata2 = s.rd2; bus.id_imm = s.imm;
        bus.id_ctrl = s.ctrl; bus.id_regwrite = s.regwrite; bus.id_memread = s.memread;
        bus.ex_alu_result = s.alu; bus.exmem_regwrite = s.mw; bus.exmem_dst = s.md;
        bus.exmem_result = s.mres;
    endtask

    // One cycle: drive at negedge, check the stall, queue the expected EX contents.
    task automatic step(input stim_t s);
        @(negedge clk);
        apply(s);
        #1;
        chk("load_use_stall", {31'd0, bus.load_use_stall}, {31'd0, must_stall(s, m)});
        m = next_ex(s, m);
        sb_q.push_back(m);
        @(posedge clk);
        #2;
        last = m;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ".ex_valid"}, {31'd0, bus.ex_valid}, 32'd0);
        chk({tag, ".ex_pc"}, bus.ex_pc, 32'd0);
        chk({tag, ".ex_opa"}, bus.ex_opa, 32'd0);
        chk({tag, ".ex_opb"}, bus.ex_opb, 32'd0);
        chk({tag, ".ex_imm"}, bus.ex_imm, 32'd0);
        chk({tag, ".ex_ctrl"}, {16'd0, bus.ex_ctrl}, 32'd0);
        chk({tag, ".ex_dst"}, {27'd0, bus.ex_dst}, 32'd0);
        chk({tag, ".ex_regwrite"}, {31'd0, bus.ex_regwrite}, 32'd0);
        chk({tag, ".ex_memread"}, {31'd0, bus.ex_memread}, 32'd0);
        chk({tag, ".stall"}, {31'd0, bus.load_use_stall}, 32'd0);
    endtask

    // Monitor: compares DUT EX register against the oldest queued expectation.
    always @(posedge clk) begin
        ex_t e;
        #1;
        if (!rst && sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("sb.valid", {31'd0, bus.ex_valid}, {31'd0, e.valid});
            chk("sb.pc", bus.ex_pc, e.pc);
            chk("sb.opa", bus.ex_opa, e.opa);
            chk("sb.opb", bus.ex_opb, e.opb);
            chk("sb.imm", bus.ex_imm, e.imm);
            chk("sb.ctrl", {16'd0, bus.ex_ctrl}, {16'd0, e.ctrl});
            chk("sb.dst", {27'd0, bus.ex_dst}, {27'd0, e.dst});
            chk("sb.regwrite", {31'd0, bus.ex_regwrite}, {31'd0, e.rw});
            chk("sb.memread", {31'd0, bus.ex_memread}, {31'd0, e.mr});
        end
    end

    function automatic stim_t rand_stim();
        stim_t s;
        s.flush = ($urandom_range(0, 9) == 0);
        s.hold = ($urandom_range(0, 7) == 0);
        s.valid = ($urandom_range(0, 7) != 0);
        s.pc = $urandom; s.rs = 5'($urandom_range(0, 7)); s.rt = 5'($urandom_range(0, 7));
        s.uses_rt = 1'($urandom); s.dst = 5'($urandom_range(0, 7));
        s.rd1 = $urandom; s.rd2 = $urandom; s.imm = $urandom; s.ctrl = 16'($urandom);
        s.regwrite = 1'($urandom); s.memread = ($urandom_range(0, 2) == 0);
        s.alu = $urandom; s.mw = 1'($urandom); s.md = 5'($urandom_range(0, 7));
        s.mres = $urandom;
        return s;
    endfunction

    initial begin
        stim_t s;
        logic [31:0] held_pc;
        m = zero_ex();
        apply(idle());
        #1;
        check_all_zero("reset0");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // EX forward beats MEM forward and the register file
        s = idle(); s.valid = 1; s.dst = 5; s.regwrite = 1; s.rs = 1; s.rt = 2; s.pc = 32'h100;
        step(s);
        s = idle(); s.valid = 1; s.rs = 5; s.rd1 = 32'h33; s.alu = 32'h11;
        s.mw = 1; s.md = 5; s.mres = 32'h22; s.dst = 3; s.regwrite = 1; s.pc = 32'h104;
        step(s);
        chk("ex_fwd.opa", bus.ex_opa, 32'h11);

        // $zero is never forwarded
        s = idle(); s.valid = 1; s.mw = 1; s.md = 0; s.mres = 32'hDEAD; s.uses_rt = 1;
        s.rd1 = 32'h77; s.rd2 = 32'h88; s.dst = 3; s.pc = 32'h108;
        step(s);
        chk("zero.opa", bus.ex_opa, 32'h0);
        chk("zero.opb", bus.ex_opb, 32'h0);

        // MEM forward on rt
        s = idle(); s.valid = 1; s.mw = 1; s.md = 7; s.mres = 32'h44; s.rt = 7; s.uses_rt = 1;
        s.rd2 = 32'h99; s.pc = 32'h10c;
        step(s);
        chk("mem_fwd.opb", bus.ex_opb, 32'h44);

        // Load-use on rt: bubble, then MEM forward of load data
        s = idle(); s.valid = 1; s.dst = 8; s.regwrite = 1; s.memread = 1; s.pc = 32'h110;
        step(s);
        s = idle(); s.valid = 1; s.rt = 8; s.uses_rt = 1; s.rs = 1; s.rd2 = 32'hBAD; s.pc = 32'h114;
        step(s);
        chk("lu.bubble_valid", {31'd0, bus.ex_valid}, 32'd0);
        s.mw = 1; s.md = 8; s.mres = 32'h55;
        step(s);
        chk("lu.replay_opb", bus.ex_opb, 32'h55);
        chk("lu.replay_valid", {31'd0, bus.ex_valid}, 32'd1);

        // rt not used: no stall
        s = idle(); s.valid = 1; s.dst = 8; s.regwrite = 1; s.memread = 1; s.pc = 32'h118;
        step(s);
        s = idle(); s.valid = 1; s.rt = 8; s.uses_rt = 0; s.rs = 1; s.pc = 32'h11c;
        step(s);
        chk("nolu.valid", {31'd0, bus.ex_valid}, 32'd1);

        // Hold for three cycles with a load-use pending, then flush with hold
        s = idle(); s.valid = 1; s.dst = 9; s.regwrite = 1; s.memread = 1; s.pc = 32'h200;
        step(s);
        held_pc = bus.ex_pc;
        s = idle(); s.valid = 1; s.hold = 1; s.rs = 9; s.pc = 32'h204;
        for (int i = 0; i < 3; i++) begin
            step(s);
            chk("hold.pc", bus.ex_pc, held_pc);
        end
        s.flush = 1;
        step(s);
        chk("flush_hold.valid", {31'd0, bus.ex_valid}, 32'd0);
        chk("flush_hold.regwrite", {31'd0, bus.ex_regwrite}, 32'd0);

        // Reset asserted mid-stall clears EX and drops the stall asynchronously
        s = idle(); s.valid = 1; s.dst = 4; s.regwrite = 1; s.memread = 1; s.pc = 32'h300;
        step(s);
        s = idle(); s.valid = 1; s.rs = 4; s.pc = 32'h304;
        @(negedge clk);
        apply(s);
        #1;
        chk("pre_reset.stall", {31'd0, bus.load_use_stall}, 32'd1);
        rst = 1'b1;
        #1;
        check_all_zero("reset_mid");
        m = zero_ex();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 500; i++) step(rand_stim());

        repeat (2) @(posedge clk);
        #3;
        chk("sb.drained", sb_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1);
    end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline boundary that sits directly downstream of the register file.
- Takes the two register read operands and resolves RAW hazards by forwarding from the EX and MEM stages. Writeback-stage results need no forwarding because the register file writes on the falling clock edge.
- Detects load-use hazards and inserts bubbles.
- Latches operands, immediate, PC and control into the EX-stage register, with flush and global-hold support.

Parameters:
CTRL_W, 16, width of opaque ALU/memory control bundle carried to EX

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous active-high reset
flush  in  1  squash the instruction entering EX (branch taken, interrupt, exception)
hold  in  1  global pipeline freeze; all stages hold together
id_valid  in  1  decode slot holds a real instruction
id_pc  in  32  PC of decoding instruction
id_rs  in  5  source register 1 index
id_rt  in  5  source register 2 index
id_uses_rt  in  1  instruction reads rt as an operand
id_dst  in  5  destination register index
id_rdata1  in  32  register file read data for rs
id_rdata2  in  32  register file read data for rt
id_imm  in  32  extended immediate
id_ctrl  in  CTRL_W  control bundle
id_regwrite  in  1  instruction writes a register
id_memread  in  1  instruction is a load
ex_alu_result  in  32  combinational result of the instruction now in EX
exmem_regwrite  in  1  MEM-stage instruction writes a register
exmem_dst  in  5  MEM-stage destination
exmem_result  in  32  MEM-stage write value (load data for loads)
ex_valid  out  1  EX register holds a real instruction
ex_pc  out  32  latched PC
ex_opa  out  32  latched forwarded rs operand
ex_opb  out  32  latched forwarded rt operand
ex_imm  out  32  latched immediate
ex_ctrl  out  CTRL_W  latched control
ex_dst  out  5  latched destination
ex_regwrite  out  1  latched regwrite, gated by valid
ex_memread  out  1  latched load flag, gated by valid
load_use_stall  out  1  combinational; IF/ID must hold and PC must not advance

Behaviour:
- Reset: asynchronous on rst=1. All ex_* outputs clear to 0; ex_valid=0. load_use_stall reads 0 while reset is asserted.
- Forwarded operand A (same rule for B with id_rt / id_rdata2):
  - If id_rs==0, A=0. $zero is never forwarded.
  - Otherwise, if ex_valid & ex_regwrite & !ex_memread & ex_dst==id_rs, A=ex_alu_result.
  - Otherwise, if exmem_regwrite & exmem_dst==id_rs, A=exmem_result.
  - Otherwise, A=id_rdata1.
  - The EX source has priority over the MEM source when both match (the youngest writer wins).
- load_use_stall = !flush & id_valid & ex_valid & ex_memread & ex_dst!=0 & (ex_dst==id_rs | (id_uses_rt & ex_dst==id_rt)).
- Rising-edge update, in priority order:
  1. flush=1: insert a bubble. ex_valid, ex_regwrite, ex_memread and ex_ctrl go to 0. The remaining ex_* fields go to 0.
  2. Else hold=1: all ex_* registers retain their values. Forwarding sources are frozen by the same hold, so there is no re-evaluation hazard.
  3. Else load_use_stall=1: insert a bubble, as in case 1.
  4. Else capture:
     - ex_valid=id_valid; ex_pc, ex_imm, ex_ctrl and ex_dst from id_*.
     - ex_opa and ex_opb take the forwarded values.
     - ex_regwrite = id_valid & id_regwrite & id_dst!=0.
     - ex_memread = id_valid & id_memread.
- Latency: 1 cycle from decode to EX. A stalled instruction re-presents on the next cycle, and its operands are then forwarded from the MEM stage.
- Flush together with hold: flush wins, and the bubble is inserted.
- Reset asserted mid-stall: the EX register clears immediately and the stall drops on the same cycle.
- An id_valid=0 instruction never raises a stall and never enables a write.

Test Plan:
- Reset: rst=1 mid-run with ex_valid=1 -> all ex_* are 0 asynchronously, before the next clk edge. load_use_stall=0.
- EX forward: EX holds an ALU write to r5 producing ex_alu_result=0x11; exmem writes r5=0x22; ID reads rs=5 with id_rdata1=0x33 -> ex_opa=0x11 after the edge.
- MEM forward / $zero: exmem writes r0=0xDEAD; ID reads rs=0, rt=0 -> ex_opa=ex_opb=0. With exmem writing r7=0x44 and rt=7, id_uses_rt=1 -> ex_opb=0x44.
- Load-use: EX is lw to r8; ID reads rt=8 with id_uses_rt=1 -> load_use_stall=1 and the next ex_valid=0. On the following cycle, with exmem_result=0x55 for r8, ex_opb=0x55. With id_uses_rt=0 there is no stall.
- Hold then flush: hold=1 for 3 cycles -> ex_* unchanged and ex_pc constant. Then flush=1 together with hold=1 -> ex_valid=0, ex_regwrite=0, load_use_stall=0.
